// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath.
// The mult/div state encoding and the MDCtrl opcodes live here.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;
  localparam int   MD_ITER = 32;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation applied to the unsigned magnitude results
// in the FIX step.
module md_sign_fix
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic               neg_prod,
  input  logic [WIDTH-1:0]   quo,
  input  logic               neg_quo,
  input  logic [WIDTH-1:0]   rem,
  input  logic               neg_rem,
  output logic [2*WIDTH-1:0] prod_fix,
  output logic [WIDTH-1:0]   quo_fix,
  output logic [WIDTH-1:0]   rem_fix
);

  assign prod_fix = neg_prod ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_quo  ? (~quo + 1'b1)  : quo;
  assign rem_fix  = neg_rem  ? (~rem + 1'b1)  : rem;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply/divide unit: 32 radix-2 steps on operand
// magnitudes, followed by one sign fix-up cycle that writes hi/lo.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one shift-add (MULT) or restoring-divide (DIV) step per cycle
// FIX   | apply signs, write hi/lo, pulse done
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int            CW   = $clog2(MD_ITER);
  localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic               op_r;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign div0  = (b == '0);
  // -2^31 maps to 2^31, which still fits as an unsigned magnitude
  assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  // MULT: mag_b shifts right, so bit 0 is the current multiplier bit
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};

  // DIV: acc = {rem, quo}; dividend bits enter from the top of mag_a
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, mag_b};
  assign rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .prod     (acc),
    .neg_prod (sign_a ^ sign_b),
    .quo      (acc[WIDTH-1:0]),
    .neg_quo  (sign_a ^ sign_b),
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .neg_rem  (sign_a),
    .prod_fix (prod_fix),
    .quo_fix  (quo_fix),
    .rem_fix  (rem_fix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= MD_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !(op == MD_DIV && div0)) begin
            op_r   <= op;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (op_r == MD_MULT) begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            mag_b <= mag_b >> 1;
          end else begin
            acc   <= {rem_next, acc[WIDTH-2:0], ~trial[WIDTH]};
            mag_a <= mag_a << 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (op_r == MD_MULT) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
